// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the RV32I-subset multicycle core: sequences fetch/decode/
// execute/memory/writeback and decodes ALU, mux and enable controls from the state.
module multicycle_control_fsm #(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [6:0]         Op,
  input  logic [2:0]         Funct3,
  input  logic               Funct7b5,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic               Illegal,
  output logic [STATE_W-1:0] State,
  output logic [CNT_W-1:0]   InstrCount
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECR    = STATE_W'(6),
    S_ALUWB    = STATE_W'(7),
    S_EXECI    = STATE_W'(8),
    S_JAL      = STATE_W'(9),
    S_BEQ      = STATE_W'(10)
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t           state_q, state_d, out_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_update, branch;
  logic [1:0]       alu_op;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: begin
        state_d = S_FETCH;
        cnt_d   = cnt_q + 1'b1;
      end
      default:   state_d = S_FETCH;
    endcase
  end

  // Outputs decode as FETCH during reset; the enables are masked separately below.
  assign out_state = RST ? S_FETCH : state_q;

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    Illegal   = 1'b0;
    case (out_state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        Illegal = !(Op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ});
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
    if (RST) begin
      pc_update = 1'b0;
      branch    = 1'b0;
      IRWrite   = 1'b0;
    end
  end

  assign PCWrite = pc_update | (branch & Zero);

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (Funct3)
          3'b000:  ALUControl = ({Op[5], Funct7b5} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (Op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign State      = state_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm; expected values are hand-derived
// from the state/output tables for each instruction class.
module tb_multicycle_control_fsm;

  logic        CLK = 1'b0;
  logic        RST;
  logic [6:0]  Op;
  logic [2:0]  Funct3;
  logic        Funct7b5;
  logic        Zero;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;
  logic [31:0] InstrCount;

  int vectors    = 0;
  int miscompares = 0;

  multicycle_control_fsm #(.STATE_W(4), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .Illegal(Illegal), .State(State),
    .InstrCount(InstrCount)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; Op = 7'b0110011; Funct3 = 3'b000; Funct7b5 = 1'b1; Zero = 1'b0;
    tick(); tick();
    chk("rst_state", State, 0);
    chk("rst_cnt", InstrCount, 0);
    chk("rst_irwrite", IRWrite, 0);
    chk("rst_pcwrite", PCWrite, 0);
    chk("rst_alusrcb", ALUSrcB, 2);
    chk("rst_resultsrc", ResultSrc, 2);

    RST = 1'b0; #1;
    chk("fetch_irwrite", IRWrite, 1);
    chk("fetch_pcwrite", PCWrite, 1);

    // R-type decode variations while parked in EXECR
    tick();
    chk("dec_state", State, 1);
    chk("dec_alusrca", ALUSrcA, 1);
    chk("dec_alusrcb", ALUSrcB, 1);
    chk("dec_pcwrite", PCWrite, 0);
    tick();
    chk("execr_state", State, 6);
    chk("execr_sub", ALUControl, 3'b001);
    chk("execr_srca", ALUSrcA, 2);
    chk("execr_srcb", ALUSrcB, 0);
    Funct7b5 = 1'b0; #1;
    chk("execr_add", ALUControl, 3'b000);
    Funct3 = 3'b111; #1;
    chk("execr_and", ALUControl, 3'b010);
    Funct3 = 3'b010; #1;
    chk("execr_slt", ALUControl, 3'b101);
    Funct3 = 3'b110; #1;
    chk("execr_or", ALUControl, 3'b011);

    RST = 1'b1; #1;
    chk("execr_rst_alu", ALUControl, 3'b000);
    chk("execr_rst_regwrite", RegWrite, 0);
    tick(); tick();
    chk("execr_rst_state", State, 0);
    RST = 1'b0;

    // lw
    Op = 7'b0000011; Funct3 = 3'b010; #1;
    chk("lw_imm", ImmSrc, 0);
    tick(); chk("lw_s1", State, 1);
    tick(); chk("lw_s2", State, 2);
    chk("lw_memadr_srcb", ALUSrcB, 1);
    tick(); chk("lw_s3", State, 3);
    chk("lw_adrsrc", AdrSrc, 1);
    chk("lw_memwrite", MemWrite, 0);
    tick(); chk("lw_s4", State, 4);
    chk("lw_regwrite", RegWrite, 1);
    chk("lw_resultsrc", ResultSrc, 1);
    chk("lw_cnt_before", InstrCount, 0);
    tick(); chk("lw_s0", State, 0);
    chk("lw_cnt", InstrCount, 1);

    // sw
    Op = 7'b0100011; #1;
    chk("sw_imm", ImmSrc, 1);
    chk("sw_mw_fetch", MemWrite, 0);
    tick(); chk("sw_s1", State, 1);
    tick(); chk("sw_s2", State, 2);
    chk("sw_mw_memadr", MemWrite, 0);
    tick(); chk("sw_s5", State, 5);
    chk("sw_memwrite", MemWrite, 1);
    chk("sw_adrsrc", AdrSrc, 1);
    chk("sw_regwrite", RegWrite, 0);
    tick(); chk("sw_s0", State, 0);
    chk("sw_mw_after", MemWrite, 0);
    chk("sw_cnt", InstrCount, 2);

    // I-type addi: Op[5]=0 so Funct7b5 does not select sub
    Op = 7'b0010011; Funct3 = 3'b000; Funct7b5 = 1'b1;
    tick(); tick();
    chk("execi_state", State, 8);
    chk("execi_add", ALUControl, 3'b000);
    chk("execi_srcb", ALUSrcB, 1);
    tick(); chk("aluwb_state", State, 7);
    chk("aluwb_regwrite", RegWrite, 1);
    chk("aluwb_resultsrc", ResultSrc, 0);
    tick(); chk("execi_cnt", InstrCount, 3);

    // jal
    Op = 7'b1101111; #1;
    chk("jal_imm", ImmSrc, 3);
    tick(); tick();
    chk("jal_state", State, 9);
    chk("jal_pcwrite", PCWrite, 1);
    chk("jal_srca", ALUSrcA, 1);
    chk("jal_srcb", ALUSrcB, 2);
    tick(); chk("jal_aluwb", State, 7);
    tick(); chk("jal_cnt", InstrCount, 4);

    // beq taken, then Zero dropped inside the same cycle
    Op = 7'b1100011; Zero = 1'b1; #1;
    chk("beq_imm", ImmSrc, 2);
    tick(); tick();
    chk("beq_state", State, 10);
    chk("beq_pcwrite_taken", PCWrite, 1);
    chk("beq_alu_sub", ALUControl, 3'b001);
    Zero = 1'b0; #1;
    chk("beq_pcwrite_drop", PCWrite, 0);
    tick(); chk("beq_s0", State, 0);
    chk("beq_cnt", InstrCount, 5);
    tick(); tick();
    chk("beq2_pcwrite", PCWrite, 0);
    tick(); chk("beq2_cnt", InstrCount, 6);

    // illegal opcode
    Op = 7'b1111111; #1;
    chk("ill_fetch", Illegal, 0);
    tick(); chk("ill_s1", State, 1);
    chk("ill_pulse", Illegal, 1);
    tick(); chk("ill_s0", State, 0);
    chk("ill_after", Illegal, 0);
    chk("ill_cnt", InstrCount, 6);

    // full R-type
    Op = 7'b0110011;
    tick(); tick(); tick(); tick();
    chk("r_s0", State, 0);
    chk("r_cnt", InstrCount, 7);

    // reset in MEMWRITE suppresses the write
    Op = 7'b0100011;
    tick(); tick(); tick();
    chk("swr_s5", State, 5);
    chk("swr_mw_pre", MemWrite, 1);
    RST = 1'b1; #1;
    chk("swr_mw_rst", MemWrite, 0);
    chk("swr_pcw_rst", PCWrite, 0);
    tick();
    chk("swr_state", State, 0);
    chk("swr_cnt", InstrCount, 0);
    RST = 1'b0; #1;
    chk("swr_fetch_ir", IRWrite, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
